id_ex_skid_stage: RTL and testbench
===================================

# id_ex_skid_stage

Parametrised ID→EX pipeline stage register with a valid/ready handshake, a two-entry skid buffer, flush, and saturating performance counters. It sits between decode and execute. It replaces the fixed-field stage with a generic payload/control split, so backpressure from EX (multi-cycle ALU, memory wait) no longer needs a global stall. Bubbles are presented downstream as all-zero control, so EX/MEM/WB never commit a non-valid beat.

## Interface
Parameters:
- DATA_W, 128, payload width (PC, operand1, operand2, immediate, instruction).
- CTRL_W, 12, control width (regwrite, memwrite, memread, alusrc, branch, aluop, datatoregsel).
- CNT_W, 16, counter width.
- CLEAR_DATA_ON_FLUSH, 1, when 1 payload registers are zeroed on flush; when 0 only control is zeroed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ID beat valid.
- in_ready  out  1  stage can accept.
- in_data  in  DATA_W  ID payload.
- in_ctrl  in  CTRL_W  ID control.
- flush  in  1  synchronous kill of all held and incoming beats.
- out_valid  out  1  EX beat valid.
- out_ready  in  1  EX accepts.
- out_data  out  DATA_W  EX payload.
- out_ctrl  out  CTRL_W  EX control, forced to 0 when out_valid=0.
- occupancy  out  2  entries held (0..2).
- cnt_clr  in  1  synchronous clear of both counters.
- flush_cnt  out  CNT_W  flush events that discarded at least one beat.
- bubble_cnt  out  CNT_W  cycles with out_ready=1 and out_valid=0.

## Operation
- Storage: main register (drives out_*) plus skid register. Beat accepted when in_valid&in_ready; beat popped when out_valid&out_ready.
- in_ready = ~skid_valid, purely registered. No combinational path from out_ready to in_ready.
- State = occupancy: EMPTY(0), HALF(1), FULL(2).
  - EMPTY: accept → HALF, main←in.
  - HALF: accept&pop → HALF, main←in. Accept only → FULL, skid←in. Pop only → EMPTY. Neither → hold.
  - FULL: in_ready=0. Pop → HALF, main←skid, skid cleared. No pop → hold.
- Order is strictly FIFO; the skid entry is never presented before main.
- flush has highest priority:
  - Next state is EMPTY.
  - main_ctrl and skid_ctrl are set to 0; payload is set to 0 if CLEAR_DATA_ON_FLUSH.
  - A beat handshaking in the flush cycle is discarded.
  - A pop in the flush cycle still completes for EX, because EX sampled it.
- out_ctrl = out_valid ? main_ctrl : 0. out_data holds its last value while invalid, unless flushed.
- flush_cnt: +1 in a cycle where flush=1 and (occupancy≠0 or in_valid=1). Saturates at 2^CNT_W-1.
- bubble_cnt: +1 in a cycle where out_ready=1 and out_valid=0. Saturates.
- cnt_clr zeroes both counters next cycle and overrides any increment in the same cycle.
- Reset values: occupancy=0, out_valid=0, out_data=0, out_ctrl=0, skid contents=0, flush_cnt=0, bubble_cnt=0. in_ready=1 during and after reset.

## Timing
- Latency: a beat accepted in cycle N is on out_* with out_valid=1 in cycle N+1 when the stage was EMPTY, or HALF with a pop.
- Throughput: 1 beat/cycle with out_ready held high. The skid is never used in that case.
- Backpressure: after out_ready deasserts, the stage absorbs exactly one more beat (HALF→FULL). in_ready drops in the following cycle.
- Release: the first pop from FULL raises in_ready next cycle. No beat is lost or duplicated.
- Flush: asserted in cycle N gives out_valid=0, occupancy=0, in_ready=1 in cycle N+1.
- Reset asserted mid-operation clears all state asynchronously. Deassertion is synchronous to clk from the user's side, and the first accept is possible on the first clk edge after release.

## Test plan
- Streaming: out_ready=1, 8 beats with in_data=i, in_ctrl=12'h0A5 → out_data 0..7 in consecutive cycles, each 1 cycle after input; occupancy never exceeds 1; bubble_cnt unchanged while streaming.
- Backpressure: drop out_ready after beat 3 while in_valid stays 1 → beat 4 held in skid, occupancy=2, in_ready=0 next cycle. Re-raise out_ready → beats 3,4,5… in order, none lost or duplicated.
- Flush in FULL: occupancy=2, in_valid=1, flush=1 → next cycle occupancy=0, out_valid=0, out_ctrl=0, out_data=0, in_ready=1, flush_cnt=1. The incoming beat never appears at the output.
- Bubble: in_valid=0, out_ready=1 for 5 cycles → bubble_cnt=5, out_ctrl=0 throughout. With CNT_W=2, 6 idle cycles → bubble_cnt saturates at 3. Then cnt_clr=1 → 0.
- Reset mid-stream: rst=0 while occupancy=2 → all outputs at reset values immediately. After release, a single beat 32'hDEAD_BEEF in the low bits appears 1 cycle after accept.
- CLEAR_DATA_ON_FLUSH=0: flush with a held payload → out_ctrl=0, out_valid=0, out_data retains the old value.

Source files
------------

// File: rtl/id_ex_skid_stage_if.sv
// Valid/ready channel bundle for the ID->EX stage: the ID-side inputs and EX-side outputs.
// Latency: none (wires only).
// Backpressure: carries in_ready upstream and out_ready downstream; no logic of its own.
//
// Signals:
//   in_valid/in_ready/in_data/in_ctrl      ID -> stage beat and its handshake
//   out_valid/out_ready/out_data/out_ctrl  stage -> EX beat and its handshake
// Modports:
//   master : environment side (drives ID beat and EX ready)
//   slave  : stage side (drives in_ready and the EX beat)
interface id_ex_skid_stage_if #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 12
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline register with a two-entry skid buffer, flush and saturating perf counters.
// Latency: 1 cycle from accept to out_valid when empty, or half-full with a pop.
// Backpressure: in_ready = ~skid occupied (registered); absorbs one beat after out_ready drops.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   bus (slave)     in_valid/in_ready/in_data/in_ctrl, out_valid/out_ready/out_data/out_ctrl
//   flush           synchronous kill of all held and incoming beats
//   occupancy       entries held (0..2)
//   cnt_clr         synchronous clear of both counters (wins over increment)
//   flush_cnt       flush events that discarded at least one beat (saturating)
//   bubble_cnt      cycles with out_ready=1 and out_valid=0 (saturating)
module id_ex_skid_stage #(
  parameter int DATA_W              = 128,
  parameter int CTRL_W              = 12,
  parameter int CNT_W               = 16,
  parameter int CLEAR_DATA_ON_FLUSH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  id_ex_skid_stage_if.slave    bus,
  input  logic                 flush,
  output logic [1:0]           occupancy,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  // State encoding equals the number of entries held, so occupancy is the state itself.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_accept;
  logic w_pop;
  logic w_flush_evt;
  logic w_bubble_evt;

  // in_ready comes straight from the state flop: the skid is occupied only in FULL.
  // No path from out_ready, so the upstream timing arc is cut.
  assign bus.in_ready  = ~r_state[1];
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign bus.out_data  = r_main_data;
  // Bubbles go downstream as all-zero control so later stages never commit them.
  assign bus.out_ctrl  = bus.out_valid ? r_main_ctrl : '0;
  assign occupancy     = r_state;
  assign flush_cnt     = r_flush_cnt;
  assign bubble_cnt    = r_bubble_cnt;

  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_pop        = bus.out_valid & bus.out_ready;
  assign w_flush_evt  = flush & ((r_state != ST_EMPTY) | bus.in_valid);
  assign w_bubble_evt = bus.out_ready & ~bus.out_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      // A pop in this cycle has already been sampled by EX; an incoming beat is dropped.
      r_state     <= ST_EMPTY;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      if (CLEAR_DATA_ON_FLUSH != 0) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_data <= bus.in_data;
            r_main_ctrl <= bus.in_ctrl;
            r_state     <= ST_HALF;
          end
        end
        ST_HALF: begin
          case ({w_accept, w_pop})
            2'b11: begin
              r_main_data <= bus.in_data;
              r_main_ctrl <= bus.in_ctrl;
            end
            2'b10: begin
              // EX stalled this cycle: park the new beat behind main.
              r_skid_data <= bus.in_data;
              r_skid_ctrl <= bus.in_ctrl;
              r_state     <= ST_FULL;
            end
            2'b01: begin
              r_state <= ST_EMPTY;
            end
            default: begin
            end
          endcase
        end
        ST_FULL: begin
          if (w_pop) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_state     <= ST_HALF;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (cnt_clr) begin
      r_flush_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_flush_evt && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (w_bubble_evt && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Bench for id_ex_skid_stage: two instances (wide counters + data clear, 2-bit counters +
// data kept on flush) share one stimulus stream and are compared each cycle against a
// FIFO-queue reference model; directed phases first, then random traffic.
module tb_id_ex_skid_stage;

  localparam int DW = 128;
  localparam int CW = 12;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } beat_t;

  logic clk;
  logic tv_rst;
  logic tv_in_valid;
  logic [DW-1:0] tv_in_data;
  logic [CW-1:0] tv_in_ctrl;
  logic tv_out_ready;
  logic tv_flush;
  logic tv_cnt_clr;

  logic [1:0]  occ_a, occ_b;
  logic [15:0] fcnt_a, bcnt_a;
  logic [1:0]  fcnt_b, bcnt_b;

  id_ex_skid_stage_if #(.DATA_W(DW), .CTRL_W(CW)) bus_a ();
  id_ex_skid_stage_if #(.DATA_W(DW), .CTRL_W(CW)) bus_b ();

  assign bus_a.in_valid  = tv_in_valid;
  assign bus_a.in_data   = tv_in_data;
  assign bus_a.in_ctrl   = tv_in_ctrl;
  assign bus_a.out_ready = tv_out_ready;
  assign bus_b.in_valid  = tv_in_valid;
  assign bus_b.in_data   = tv_in_data;
  assign bus_b.in_ctrl   = tv_in_ctrl;
  assign bus_b.out_ready = tv_out_ready;

  id_ex_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16), .CLEAR_DATA_ON_FLUSH(1)) dut_a (
    .clk(clk), .rst(tv_rst), .bus(bus_a), .flush(tv_flush), .occupancy(occ_a),
    .cnt_clr(tv_cnt_clr), .flush_cnt(fcnt_a), .bubble_cnt(bcnt_a)
  );

  id_ex_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(2), .CLEAR_DATA_ON_FLUSH(0)) dut_b (
    .clk(clk), .rst(tv_rst), .bus(bus_b), .flush(tv_flush), .occupancy(occ_b),
    .cnt_clr(tv_cnt_clr), .flush_cnt(fcnt_b), .bubble_cnt(bcnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: ordered list of held beats, the value the output register shows,
  // and the two counter pairs.
  beat_t q[$];
  logic [DW-1:0] shown_a, shown_b;
  int m_fcnt_a, m_bcnt_a, m_fcnt_b, m_bcnt_b;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    shown_a  = '0;
    shown_b  = '0;
    m_fcnt_a = 0;
    m_bcnt_a = 0;
    m_fcnt_b = 0;
    m_bcnt_b = 0;
  endtask

  function automatic int sat_inc(input int v, input bit evt, input bit clr, input int maxv);
    if (clr) return 0;
    if (evt && v < maxv) return v + 1;
    return v;
  endfunction

  task automatic model_step();
    bit acc, pop, fevt, bevt;
    beat_t b;
    acc  = tv_in_valid && (q.size() < 2);
    pop  = (q.size() > 0) && tv_out_ready;
    fevt = tv_flush && ((q.size() != 0) || tv_in_valid);
    bevt = tv_out_ready && (q.size() == 0);
    m_fcnt_a = sat_inc(m_fcnt_a, fevt, tv_cnt_clr, 65535);
    m_bcnt_a = sat_inc(m_bcnt_a, bevt, tv_cnt_clr, 65535);
    m_fcnt_b = sat_inc(m_fcnt_b, fevt, tv_cnt_clr, 3);
    m_bcnt_b = sat_inc(m_bcnt_b, bevt, tv_cnt_clr, 3);
    if (tv_flush) begin
      q.delete();
      shown_a = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        b.data = tv_in_data;
        b.ctrl = tv_in_ctrl;
        q.push_back(b);
      end
    end
    if (q.size() > 0) begin
      shown_a = q[0].data;
      shown_b = q[0].data;
    end
  endtask

  task automatic compare_all();
    logic [CW-1:0] exp_ctrl;
    int n;
    n = q.size();
    exp_ctrl = '0;
    if (n > 0) exp_ctrl = q[0].ctrl;
    check("occupancy_a", DW'(occ_a), DW'(n));
    check("occupancy_b", DW'(occ_b), DW'(n));
    check("in_ready", DW'(bus_a.in_ready), DW'(n < 2));
    check("out_valid_a", DW'(bus_a.out_valid), DW'(n > 0));
    check("out_valid_b", DW'(bus_b.out_valid), DW'(n > 0));
    check("out_ctrl_a", DW'(bus_a.out_ctrl), DW'(exp_ctrl));
    check("out_ctrl_b", DW'(bus_b.out_ctrl), DW'(exp_ctrl));
    check("out_data_a", bus_a.out_data, shown_a);
    check("out_data_b", bus_b.out_data, shown_b);
    check("flush_cnt_a", DW'(fcnt_a), DW'(m_fcnt_a));
    check("bubble_cnt_a", DW'(bcnt_a), DW'(m_bcnt_a));
    check("flush_cnt_b", DW'(fcnt_b), DW'(m_fcnt_b));
    check("bubble_cnt_b", DW'(bcnt_b), DW'(m_bcnt_b));
  endtask

  // Called at a negedge: check current state, apply inputs, advance model at posedge.
  task automatic run_cycle(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                           input bit ordy, input bit fl, input bit clr);
    compare_all();
    tv_in_valid  = iv;
    tv_in_data   = d;
    tv_in_ctrl   = c;
    tv_out_ready = ordy;
    tv_flush     = fl;
    tv_cnt_clr   = clr;
    @(posedge clk);
    if (tv_rst) model_step();
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] rd;
    tv_rst       = 1'b0;
    tv_in_valid  = 1'b0;
    tv_in_data   = '0;
    tv_in_ctrl   = '0;
    tv_out_ready = 1'b0;
    tv_flush     = 1'b0;
    tv_cnt_clr   = 1'b0;
    model_reset();

    // Reset state, including in_ready=1 while held in reset.
    repeat (2) @(negedge clk);
    compare_all();
    @(negedge clk);
    tv_rst = 1'b1;

    // Streaming: 8 beats back to back with EX always ready.
    for (int i = 0; i < 8; i++) run_cycle(1'b1, DW'(i), 12'h0A5, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure: EX stalls while ID keeps offering, then releases.
    for (int i = 0; i < 4; i++) run_cycle(1'b1, DW'(16 + i), 12'h0A5, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i < 7; i++) run_cycle(1'b1, DW'(16 + i), 12'h0A5, 1'b0, 1'b0, 1'b0);
    for (int i = 7; i < 12; i++) run_cycle(1'b1, DW'(16 + i), 12'h05A, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while FULL with a beat arriving.
    for (int i = 0; i < 3; i++) run_cycle(1'b1, DW'(32'hA0 + i), 12'h3C3, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, DW'(32'hBAD), 12'hFFF, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Flush with a held payload in HALF and a pop in the same cycle.
    run_cycle(1'b1, DW'(32'h1234), 12'h111, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Bubbles: idle with EX ready; the 2-bit counters saturate, then clear.
    for (int i = 0; i < 6; i++) run_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      run_cycle($urandom_range(0, 9) < 7, rd, CW'($urandom),
                $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0,
                $urandom_range(0, 31) == 0);
    end

    // Reset mid-stream while FULL: outputs must clear without waiting for a clock.
    for (int i = 0; i < 3; i++) run_cycle(1'b1, DW'(32'hC0 + i), 12'h777, 1'b0, 1'b0, 1'b0);
    compare_all();
    #2;
    tv_rst = 1'b0;
    #1;
    check("async_rst_occupancy", DW'(occ_a), DW'(0));
    check("async_rst_out_valid", DW'(bus_a.out_valid), DW'(0));
    check("async_rst_out_data", bus_a.out_data, DW'(0));
    check("async_rst_out_ctrl", DW'(bus_a.out_ctrl), DW'(0));
    check("async_rst_in_ready", DW'(bus_a.in_ready), DW'(1));
    check("async_rst_out_data_b", bus_b.out_data, DW'(0));
    model_reset();
    tv_in_valid = 1'b0;
    @(negedge clk);
    compare_all();
    tv_rst = 1'b1;
    run_cycle(1'b1, DW'(32'hDEAD_BEEF), 12'h0A5, 1'b0, 1'b0, 1'b0);
    check("deadbeef_data", bus_a.out_data, DW'(32'hDEAD_BEEF));
    check("deadbeef_valid", DW'(bus_a.out_valid), DW'(1));
    run_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
